// File: rtl/oki_rom_fetch.sv
// Sample-ROM read responder for the OKI6295: serves banked byte reads from 16-bit SDRAM
// through a two-line word cache with optional sequential next-word prefetch.
module oki_rom_fetch #(
  parameter logic [19:0] ROM_OFFS = 20'h0,
  parameter bit          PREFETCH = 1'b1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        OKI_CS,
  input  logic [20:0] OKI_ADDR,
  output logic [7:0]  OKI_DATA,
  output logic        OKI_OK,
  output logic        ROM_CS,
  output logic [19:0] ROM_ADDR,
  input  logic [15:0] ROM_DATA,
  input  logic        ROM_OK
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StDemand = 2'd1;
  localparam logic [1:0] StPref   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [19:0]       fetch_q, fetch_d;
  logic              lru_q, lru_d;
  logic              dem_line_q, dem_line_d;
  logic              pend_pf_q, pend_pf_d;
  logic [19:0]       pf_word_q, pf_word_d;
  logic [1:0]        valid_q, valid_d;
  logic [1:0][19:0]  tag_q, tag_d;
  logic [1:0][15:0]  data_q, data_d;
  logic [7:0]        oki_data_q, oki_data_d;
  logic              oki_ok_q, oki_ok_d;
  logic              rom_cs_q, rom_cs_d;
  logic [19:0]       rom_addr_q, rom_addr_d;

  logic [19:0] word;
  logic [1:0]  hit_vec;
  logic        hit;
  logic [15:0] hit_data;
  logic        rom_fire;
  logic [19:0] next_word;
  logic        other;
  logic        pf_needed;

  assign word      = OKI_ADDR[20:1];
  assign hit_vec   = {valid_q[1] && (tag_q[1] == word), valid_q[0] && (tag_q[0] == word)};
  assign hit       = |hit_vec;
  assign hit_data  = hit_vec[1] ? data_q[1] : data_q[0];
  // Late ROM_OK after a reset-aborted request must not fill anything.
  assign rom_fire  = rom_cs_q && ROM_OK;
  assign next_word = fetch_q + 20'd1;
  assign other     = ~lru_q;
  assign pf_needed = PREFETCH && !(valid_q[other] && (tag_q[other] == next_word));

  always_comb begin
    state_d    = state_q;
    fetch_d    = fetch_q;
    lru_d      = lru_q;
    dem_line_d = dem_line_q;
    pend_pf_d  = pend_pf_q;
    pf_word_d  = pf_word_q;
    valid_d    = valid_q;
    tag_d      = tag_q;
    data_d     = data_q;
    oki_data_d = oki_data_q;
    oki_ok_d   = 1'b0;
    rom_cs_d   = rom_cs_q;
    rom_addr_d = rom_addr_q;

    unique case (state_q)
      StIdle: begin
        if (OKI_CS && hit) begin
          oki_ok_d   = 1'b1;
          oki_data_d = OKI_ADDR[0] ? hit_data[15:8] : hit_data[7:0];
          lru_d      = ~hit_vec[1];
        end
        // A demand miss wins over a pending prefetch, which stays pending.
        if (OKI_CS && !hit) begin
          state_d    = StDemand;
          fetch_d    = word;
          rom_cs_d   = 1'b1;
          rom_addr_d = word + ROM_OFFS;
        end else if (pend_pf_q) begin
          state_d    = StPref;
          fetch_d    = pf_word_q;
          rom_cs_d   = 1'b1;
          rom_addr_d = pf_word_q + ROM_OFFS;
        end
      end
      StDemand: begin
        if (rom_fire) begin
          data_d[lru_q]  = ROM_DATA;
          tag_d[lru_q]   = fetch_q;
          valid_d[lru_q] = 1'b1;
          lru_d          = ~lru_q;
          dem_line_d     = lru_q;
          rom_cs_d       = 1'b0;
          state_d        = StIdle;
          if (pf_needed) begin
            pend_pf_d = 1'b1;
            pf_word_d = next_word;
          end
        end
      end
      StPref: begin
        if (rom_fire) begin
          data_d[~dem_line_q]  = ROM_DATA;
          tag_d[~dem_line_q]   = fetch_q;
          valid_d[~dem_line_q] = 1'b1;
          pend_pf_d            = 1'b0;
          rom_cs_d             = 1'b0;
          state_d              = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= StIdle;
      fetch_q    <= 20'h0;
      lru_q      <= 1'b0;
      dem_line_q <= 1'b0;
      pend_pf_q  <= 1'b0;
      pf_word_q  <= 20'h0;
      valid_q    <= 2'b00;
      tag_q      <= '0;
      data_q     <= '0;
      oki_data_q <= 8'h0;
      oki_ok_q   <= 1'b0;
      rom_cs_q   <= 1'b0;
      rom_addr_q <= 20'h0;
    end else begin
      state_q    <= state_d;
      fetch_q    <= fetch_d;
      lru_q      <= lru_d;
      dem_line_q <= dem_line_d;
      pend_pf_q  <= pend_pf_d;
      pf_word_q  <= pf_word_d;
      valid_q    <= valid_d;
      tag_q      <= tag_d;
      data_q     <= data_d;
      oki_data_q <= oki_data_d;
      oki_ok_q   <= oki_ok_d;
      rom_cs_q   <= rom_cs_d;
      rom_addr_q <= rom_addr_d;
    end
  end

  assign OKI_DATA = oki_data_q;
  assign OKI_OK   = oki_ok_q;
  assign ROM_CS   = rom_cs_q;
  assign ROM_ADDR = rom_addr_q;

endmodule
